// File: rtl/flopr_pkg.sv
// Shared datapath constants for the pipeline that instantiates flopr stages.
// flopr itself does not import this package; only its users do.
package flopr_pkg;

  localparam int WORD      = 32;
  localparam int REG_SIZE  = 5;
  localparam int REG_COUNT = 32;

  // Decode-to-execute payload: four operand/immediate words plus three control bits.
  localparam int DE_STAGE_WIDTH = 4 * WORD + 3;

  typedef logic [WORD-1:0]     word_t;
  typedef logic [REG_SIZE-1:0] reg_idx_t;

  function automatic int stage_width(input int n_words, input int n_ctrl_bits);
    return n_words * WORD + n_ctrl_bits;
  endfunction

endpackage

// File: rtl/flopr.sv
// Parameterized pipeline register: async active-low reset, synchronous clear
// (bubble) and load enable (stall). q comes straight from the storage flops.
module flopr #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (WIDTH == 0 || WIDTH > 1024) begin : g_width_illegal
    $error("flopr: WIDTH=%0d is outside the legal range 1..1024", WIDTH);
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Conditional operators rather than if/else so an X on clr or en merges
  // into q_d instead of silently selecting one branch.
  assign q_d = clr ? CLEAR_VAL : (en ? d : q_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

  // Clear wins over enable whatever en is doing.
  property p_clear;
    @(posedge clk) disable iff (!reset)
      clr |=> (q == CLEAR_VAL);
  endproperty
  a_clear: assert property (p_clear)
    else $error("flopr: clear did not load CLEAR_VAL");

  property p_capture;
    @(posedge clk) disable iff (!reset)
      (!clr && en) |=> (q == $past(d));
  endproperty
  a_capture: assert property (p_capture)
    else $error("flopr: enabled edge did not capture d");

  property p_hold;
    @(posedge clk) disable iff (!reset)
      (!clr && !en) |=> (q == $past(q));
  endproperty
  a_hold: assert property (p_hold)
    else $error("flopr: stalled edge changed q");

  // Reset is asynchronous, so q must already show RESET_VAL at either clock edge.
  property p_reset_pos;
    @(posedge clk) !reset |-> (q == RESET_VAL);
  endproperty
  a_reset_pos: assert property (p_reset_pos)
    else $error("flopr: q not at RESET_VAL while reset asserted");

  property p_reset_neg;
    @(negedge clk) !reset |-> (q == RESET_VAL);
  endproperty
  a_reset_neg: assert property (p_reset_neg)
    else $error("flopr: q not at RESET_VAL while reset asserted");

endmodule

// File: tb/tb_flopr.sv
// Self-checking bench for flopr: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_flopr;
  import flopr_pkg::*;

  localparam int          W_WIDE = DE_STAGE_WIDTH;
  localparam logic [7:0]  RV8    = 8'h5A;
  localparam logic [7:0]  CV8    = 8'h13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic              en    = 1'b0;
  logic              clr   = 1'b0;
  logic [7:0]        d8    = '0;
  logic [7:0]        q8;
  logic [W_WIDE-1:0] dw    = '0;
  logic [W_WIDE-1:0] qw;

  flopr #(.WIDTH(8), .RESET_VAL(RV8), .CLEAR_VAL(CV8)) u_narrow (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .d(d8), .q(q8)
  );

  flopr #(.WIDTH(W_WIDE)) u_wide (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .d(dw), .q(qw)
  );

  // Model state: what each register must hold right now.
  logic [7:0]        m8 = RV8;
  logic [W_WIDE-1:0] mw = '0;
  int  vectors = 0;
  int  errors  = 0;
  bit  check_on = 1'b0;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: q=%h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [W_WIDE-1:0] act, input logic [W_WIDE-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: q=%h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W_WIDE-1:0] rand_wide();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[W_WIDE-1:0];
  endfunction

  // One clock transaction: apply inputs, take the edge, advance the model.
  task automatic step(input logic e, input logic c, input logic [7:0] a, input logic [W_WIDE-1:0] b);
    en = e; clr = c; d8 = a; dw = b;
    @(posedge clk);
    if (!reset) begin
      m8 = RV8; mw = '0;
    end else if (c) begin
      m8 = CV8; mw = '0;
    end else if (e) begin
      m8 = a; mw = b;
    end
    #1;
  endtask

  task automatic assert_reset_now();
    reset = 1'b0;
    m8 = RV8; mw = '0;
  endtask

  always @(negedge clk) begin
    if (check_on) begin
      chk8("model_q8", q8, m8);
      chkw("model_qw", qw, mw);
    end
  end

  initial begin
    #1 assert_reset_now();
    #1 check_on = 1'b1;
    chk8("reset_q8", q8, 8'h5A);
    chkw("reset_qw", qw, '0);

    // Reset held: edges with live inputs must not disturb q.
    step(1'b1, 1'b0, 8'hC3, '1);
    step(1'b1, 1'b1, 8'hC3, '1);
    chk8("reset_hold_q8", q8, 8'h5A);

    // Release mid-cycle with en=1, d=0x11: no change until the next edge.
    en = 1'b1; d8 = 8'h11; dw = '0;
    #2 reset = 1'b1;
    #1 chk8("release_no_effect", q8, 8'h5A);
    step(1'b1, 1'b0, 8'h11, '0);
    chk8("release_first_edge", q8, 8'h11);

    step(1'b1, 1'b0, 8'hA5, '0);
    chk8("capture_a5", q8, 8'hA5);
    step(1'b1, 1'b0, 8'h3C, '0);
    chk8("capture_3c", q8, 8'h3C);

    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 8'hFF, '1);
      chk8("stall_3c", q8, 8'h3C);
    end
    step(1'b1, 1'b0, 8'hFF, '0);
    chk8("stall_release_ff", q8, 8'hFF);

    step(1'b1, 1'b1, 8'h77, '1);
    chk8("flush_13", q8, 8'h13);
    chkw("flush_wide_0", qw, '0);
    step(1'b1, 1'b0, 8'h77, '0);
    chk8("after_flush_77", q8, 8'h77);

    // Wide stage: load all-ones, then drop reset mid-cycle.
    step(1'b1, 1'b0, 8'h22, '1);
    chkw("wide_all_ones", qw, '1);
    #2 assert_reset_now();
    #1 chkw("async_reset_wide", qw, '0);
    chk8("async_reset_narrow", q8, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 8'hEE, '1);
      chkw("reset_stays_0", qw, '0);
    end
    #2 reset = 1'b1;

    // Randomized traffic with occasional mid-cycle reset pulses.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 8'($urandom), rand_wide());
      if ($urandom_range(0, 24) == 0) begin
        #2;
        if (reset) assert_reset_now();
        else reset = 1'b1;
      end
    end
    if (!reset) begin
      #2 reset = 1'b1;
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 8'($urandom), rand_wide());
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
